// File: rtl/alu_regfile_seq.sv
// Register file, N-bit ALU and status flags behind a valid/ready command port.
// A lane sequencer runs carry-chained multi-lane word operations, one lane per enabled cycle.
module alu_regfile_seq #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned ADR_W     = 5,
  parameter int unsigned MAX_LANES = 4
) (
  input  logic              cp2,
  input  logic              ireset,
  input  logic              cp2en,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [ADR_W-1:0]  rd_adr,
  input  logic [ADR_W-1:0]  rr_adr,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [2:0]        lanes,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result_out,
  output logic [7:0]        sreg_out,
  input  logic [ADR_W-1:0]  dbg_adr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_EOR = 4'd6,  OP_COM = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8,  OP_INC = 4'd9,  OP_DEC = 4'd10, OP_CP  = 4'd11;
  localparam logic [3:0] OP_CPC = 4'd12, OP_LSR = 4'd13, OP_ROR = 4'd14, OP_LDI = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_op;
  logic [ADR_W-1:0]    r_rd, r_rr;
  logic [DATA_W-1:0]   r_imm;
  logic                r_ui;
  logic [2:0]          r_nl, r_k;
  logic                r_cy, r_zacc;
  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [5:0]          r_sreg;
  logic [DATA_W-1:0]   r_result;

  logic [2:0]          w_lanes_eff;
  logic [ADR_W-1:0]    w_rd_k, w_rr_k;
  logic [DATA_W-1:0]   w_d, w_r, w_a, w_b, w_res;
  logic [DATA_W:0]     w_sum, w_dif;
  logic [4:0]          w_hsum, w_hdif;
  logic                w_first, w_last, w_cin, w_co, w_c, w_v, w_h, w_n, w_z, w_zall, w_wr;
  logic                w_vadd, w_vsub;
  logic [5:0]          w_sreg_nxt;

  always_comb begin
    w_lanes_eff = lanes;
    if (lanes == 3'd0)               w_lanes_eff = 3'd1;
    else if (32'(lanes) > MAX_LANES) w_lanes_eff = 3'(MAX_LANES);
  end

  assign w_first = (r_k == 3'd0);
  assign w_last  = (r_k == r_nl - 3'd1);
  assign w_rd_k  = r_rd + ADR_W'(r_k);
  assign w_rr_k  = r_rr + ADR_W'(r_k);
  assign w_d     = r_regs[w_rd_k];
  assign w_r     = r_ui ? (w_first ? r_imm : '0) : r_regs[w_rr_k];

  // Lane 0 pulls SREG.C only for the carry-consuming ops; later lanes chain.
  always_comb begin
    w_cin = r_cy;
    if (w_first)
      w_cin = (r_op == OP_ADC || r_op == OP_SBC || r_op == OP_CPC || r_op == OP_ROR) ? r_sreg[0] : 1'b0;
  end

  always_comb begin
    w_a = (r_op == OP_NEG) ? '0 : w_d;
    w_b = w_r;
    if (r_op == OP_INC || r_op == OP_DEC) w_b = DATA_W'(w_first);
    else if (r_op == OP_NEG)              w_b = w_d;
  end

  assign w_sum  = {1'b0, w_a} + {1'b0, w_b} + (DATA_W+1)'(w_cin);
  assign w_dif  = {1'b0, w_a} - {1'b0, w_b} - (DATA_W+1)'(w_cin);
  assign w_hsum = {1'b0, w_a[3:0]} + {1'b0, w_b[3:0]} + 5'(w_cin);
  assign w_hdif = {1'b0, w_a[3:0]} - {1'b0, w_b[3:0]} - 5'(w_cin);
  assign w_vadd = (w_a[DATA_W-1] & w_b[DATA_W-1] & ~w_sum[DATA_W-1]) |
                  (~w_a[DATA_W-1] & ~w_b[DATA_W-1] & w_sum[DATA_W-1]);
  assign w_vsub = (w_a[DATA_W-1] & ~w_b[DATA_W-1] & ~w_dif[DATA_W-1]) |
                  (~w_a[DATA_W-1] & w_b[DATA_W-1] & w_dif[DATA_W-1]);

  // Per-lane result and the flag candidates used if this is the last lane.
  always_comb begin
    w_res = w_sum;
    w_res = w_sum[DATA_W-1:0];
    w_co  = 1'b0;
    w_c   = r_sreg[0];
    w_v   = 1'b0;
    w_h   = 1'b0;
    w_wr  = 1'b1;
    case (r_op)
      OP_ADD, OP_ADC: begin
        w_co = w_sum[DATA_W]; w_c = w_co; w_v = w_vadd; w_h = w_hsum[4];
      end
      OP_INC: begin
        w_co = w_sum[DATA_W]; w_v = w_vadd;
      end
      OP_SUB, OP_SBC, OP_NEG, OP_CP, OP_CPC: begin
        w_res = w_dif[DATA_W-1:0];
        w_co  = w_dif[DATA_W]; w_c = w_co; w_v = w_vsub; w_h = w_hdif[4];
        w_wr  = (r_op != OP_CP) && (r_op != OP_CPC);
      end
      OP_DEC: begin
        w_res = w_dif[DATA_W-1:0];
        w_co  = w_dif[DATA_W]; w_v = w_vsub;
      end
      OP_AND: w_res = w_d & w_r;
      OP_OR:  w_res = w_d | w_r;
      OP_EOR: w_res = w_d ^ w_r;
      OP_COM: begin
        w_res = ~w_d; w_c = 1'b1;
      end
      OP_LSR, OP_ROR: begin
        w_res = {w_cin, w_d[DATA_W-1:1]};
        w_co  = w_d[0]; w_c = w_co; w_v = w_res[DATA_W-1] ^ w_co;
      end
      default: w_res = r_imm;
    endcase
  end

  assign w_n        = w_res[DATA_W-1];
  assign w_zall     = r_zacc & (w_res == '0);
  assign w_z        = (r_op == OP_ADC || r_op == OP_SBC || r_op == OP_CPC) ? (w_zall & r_sreg[1]) : w_zall;
  assign w_sreg_nxt = {w_h, w_n ^ w_v, w_v, w_n, w_z, w_c};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (op_valid) w_state_nxt = S_EXEC;
      S_EXEC:  if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge cp2) begin
    if (ireset)     r_state <= S_IDLE;
    else if (cp2en) r_state <= w_state_nxt;
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
      r_op <= '0; r_rd <= '0; r_rr <= '0; r_imm <= '0; r_ui <= 1'b0;
      r_nl <= 3'd1; r_k <= '0; r_cy <= 1'b0; r_zacc <= 1'b1;
      r_sreg <= '0; r_result <= '0;
    end else if (cp2en) begin
      if (r_state == S_IDLE && op_valid) begin
        r_op <= op_code; r_rd <= rd_adr; r_rr <= rr_adr; r_imm <= imm; r_ui <= use_imm;
        r_nl <= w_lanes_eff; r_k <= '0; r_zacc <= 1'b1;
      end else if (r_state == S_EXEC) begin
        if (w_wr) r_regs[w_rd_k] <= w_res;
        r_result <= w_res;
        r_cy     <= w_co;
        r_zacc   <= w_zall;
        r_k      <= r_k + 3'd1;
        if (w_last && r_op != OP_LDI) r_sreg <= w_sreg_nxt;
      end
    end
  end

  assign op_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign result_out = r_result;
  assign sreg_out   = {2'b00, r_sreg};
  assign dbg_data   = r_regs[dbg_adr];

endmodule
